if_stage: RTL and testbench

//  Fetch stage of the 5-stage MIPS pipeline. Owns the architectural PC[31:2], issues

---
 rtl/if_stage_if.sv | 10 +
 rtl/if_stage.sv | 173 +++++++++++++++++
 tb/tb_if_stage.sv | 185 ++++++++++++++++++
 3 files changed

// File: rtl/if_stage_if.sv
// Instruction-memory fetch bus between the IF stage (master) and the instruction memory (slave).
interface if_stage_if;
  logic        imem_req;
  logic [29:0] imem_addr;
  logic [31:0] imem_rdata;
  logic        imem_ready;

  modport master (output imem_req, imem_addr, input imem_rdata, imem_ready);
  modport slave  (input imem_req, imem_addr, output imem_rdata, imem_ready);
endinterface

// File: rtl/if_stage.sv
// MIPS fetch stage: owns PC[31:2], issues imem reads and loads the IF/ID register.
// IMEM_WAIT_EN selects the multi-cycle memory handshake (FSM RUN/KILL/HOLD); default is single-cycle.
module if_stage #(
  parameter logic [31:0] RESET_PC  = 32'h0000_3000,
  parameter logic [31:0] NOP_INSTR = 32'h0000_0000
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               redirect,
  input  logic [29:0]        npc,
  input  logic               stall,
  input  logic               flush,
  if_stage_if.master         imem,
  output logic               if_id_valid,
  output logic [31:0]        if_id_instr,
  output logic [29:0]        if_id_pcp1
);

  typedef enum logic [1:0] {RUN = 2'd0, KILL = 2'd1, HOLD = 2'd2} state_e;

  state_e      state_q, state_d;
  logic [29:0] pc_q, pc_d;
  logic [29:0] pend_q, pend_d;
  logic [31:0] skid_instr_q, skid_instr_d;
  logic [29:0] skid_pcp1_q, skid_pcp1_d;
  logic        id_valid_q, id_valid_d;
  logic [31:0] id_instr_q, id_instr_d;
  logic [29:0] id_pcp1_q, id_pcp1_d;
  logic        out_q, out_d;

  logic        ready, req, red, acc, busy;
  logic [29:0] pc_inc;

`ifdef IMEM_WAIT_EN
  assign ready = imem.imem_ready;
`else
  assign ready = 1'b1;
`endif

  // A redirect under stall is ignored (ID re-presents it), unless a flush forces the kill.
  assign red    = redirect && (flush || !stall);
  assign acc    = req && ready;
  assign busy   = req && !ready;
  assign pc_inc = pc_q + 30'd1;

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= RUN;
      pc_q         <= RESET_PC[31:2];
      pend_q       <= '0;
      skid_instr_q <= '0;
      skid_pcp1_q  <= '0;
      id_valid_q   <= 1'b0;
      id_instr_q   <= NOP_INSTR;
      id_pcp1_q    <= '0;
      out_q        <= 1'b0;
    end else begin
      state_q      <= state_d;
      pc_q         <= pc_d;
      pend_q       <= pend_d;
      skid_instr_q <= skid_instr_d;
      skid_pcp1_q  <= skid_pcp1_d;
      id_valid_q   <= id_valid_d;
      id_instr_q   <= id_instr_d;
      id_pcp1_q    <= id_pcp1_d;
      out_q        <= out_d;
    end
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      RUN:     if (red && busy) state_d = KILL;
               else if (!flush && !red && stall && acc) state_d = HOLD;
      KILL:    if (ready) state_d = RUN;
      HOLD:    if (flush || red || !stall) state_d = RUN;
      default: state_d = RUN;
    endcase
`ifndef IMEM_WAIT_EN
    state_d = RUN;
`endif
  end

  // An outstanding request keeps req up through a stall so addr/req stay stable.
  always_comb begin
    req = 1'b0;
    if (!rst) begin
      unique case (state_q)
        RUN:     req = !stall || out_q;
        KILL:    req = 1'b1;
        default: req = 1'b0;
      endcase
    end
  end

  assign imem.imem_req  = req;
  assign imem.imem_addr = pc_q;

  always_comb begin
    pc_d         = pc_q;
    pend_d       = pend_q;
    skid_instr_d = skid_instr_q;
    skid_pcp1_d  = skid_pcp1_q;
    id_valid_d   = id_valid_q;
    id_instr_d   = id_instr_q;
    id_pcp1_d    = id_pcp1_q;
    out_d        = out_q;
    unique case (state_q)
      RUN: begin
        if (flush || red) begin
          id_valid_d = 1'b0;
          id_instr_d = NOP_INSTR;
          id_pcp1_d  = '0;
          if (red && busy) begin
            pend_d = npc;
          end else begin
            if (red) pc_d = npc;
            out_d = busy;
          end
        end else if (stall) begin
          if (acc) begin
            skid_instr_d = imem.imem_rdata;
            skid_pcp1_d  = pc_inc;
            pc_d         = pc_inc;
            out_d        = 1'b0;
          end
        end else if (acc) begin
          id_valid_d = 1'b1;
          id_instr_d = imem.imem_rdata;
          id_pcp1_d  = pc_inc;
          pc_d       = pc_inc;
          out_d      = 1'b0;
        end else begin
          id_valid_d = 1'b0;
          id_instr_d = NOP_INSTR;
          id_pcp1_d  = '0;
          out_d      = 1'b1;
        end
      end
      KILL: begin
        if (red) pend_d = npc;
        if (flush || !stall) begin
          id_valid_d = 1'b0;
          id_instr_d = NOP_INSTR;
          id_pcp1_d  = '0;
        end
        // Response to the killed address is dropped; latest target wins.
        if (ready) begin
          pc_d  = red ? npc : pend_q;
          out_d = 1'b0;
        end
      end
      HOLD: begin
        if (flush || red) begin
          id_valid_d = 1'b0;
          id_instr_d = NOP_INSTR;
          id_pcp1_d  = '0;
          if (red) pc_d = npc;
        end else if (!stall) begin
          id_valid_d = 1'b1;
          id_instr_d = skid_instr_q;
          id_pcp1_d  = skid_pcp1_q;
        end
      end
      default: ;
    endcase
  end

  assign if_id_valid = id_valid_q;
  assign if_id_instr = id_instr_q;
  assign if_id_pcp1  = id_pcp1_q;

endmodule

// File: tb/tb_if_stage.sv
// Self-checking bench for if_stage: spec-level fetch model feeding an expectation queue.
module tb_if_stage;
  localparam logic [31:0] NOP = 32'hFC00_0000;

  logic        clk = 1'b0;
  logic        rst, redirect, stall, flush;
  logic [29:0] npc;
  logic        if_id_valid;
  logic [31:0] if_id_instr;
  logic [29:0] if_id_pcp1;

  if_stage_if bus();

  if_stage #(.RESET_PC(32'h0000_3000), .NOP_INSTR(NOP)) dut (
    .clk(clk), .rst(rst), .redirect(redirect), .npc(npc), .stall(stall), .flush(flush),
    .imem(bus.master), .if_id_valid(if_id_valid), .if_id_instr(if_id_instr),
    .if_id_pcp1(if_id_pcp1)
  );

  always #5 clk = ~clk;

  function automatic logic [31:0] mem_word(input logic [29:0] a);
    return {a, 2'b01} ^ 32'h5A5A_0000;
  endfunction

  assign bus.imem_rdata = mem_word(bus.imem_addr);

  int n_chk = 0;
  int n_fail = 0;

  task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h want %h", tag, act, exp);
    end
  endtask

  typedef struct {
    logic        v;
    logic [31:0] i;
    logic [29:0] p;
    logic [29:0] a;
  } exp_t;
  exp_t q[$];

  logic        mv;
  logic [31:0] mi;
  logic [29:0] mp, mpc;

  task automatic step(input logic st, input logic rd, input logic [29:0] np, input logic fl);
    exp_t e;
    @(negedge clk);
    stall = st; redirect = rd; npc = np; flush = fl;
    #1;
    chk("req", 32'(bus.imem_req), 32'(!st));
    chk("addr_pre", 32'(bus.imem_addr), 32'(mpc));
    if (fl) begin
      mv = 1'b0; mi = NOP; mp = '0;
      if (rd) mpc = np;
    end else if (rd && !st) begin
      mv = 1'b0; mi = NOP; mp = '0;
      mpc = np;
    end else if (!st) begin
      mv = 1'b1; mi = mem_word(mpc); mp = mpc + 30'd1;
      mpc = mpc + 30'd1;
    end
    e = '{mv, mi, mp, mpc};
    q.push_back(e);
    @(posedge clk);
    #1;
    e = q.pop_front();
    chk("valid", 32'(if_id_valid), 32'(e.v));
    chk("instr", if_id_instr, e.i);
    chk("pcp1", 32'(if_id_pcp1), 32'(e.p));
    chk("addr", 32'(bus.imem_addr), 32'(e.a));
  endtask

  initial begin
    rst = 1'b1; stall = 1'b0; redirect = 1'b0; flush = 1'b0; npc = '0;
    bus.imem_ready = 1'b1;
    mv = 1'b0; mi = NOP; mp = '0; mpc = 30'hC00;

    @(negedge clk);
    chk("rst_req", 32'(bus.imem_req), 32'd0);
    @(posedge clk);
    #1;
    rst = 1'b0;
    #1;
    chk("rst_valid", 32'(if_id_valid), 32'd0);
    chk("rst_instr", if_id_instr, NOP);
    chk("rst_pcp1", 32'(if_id_pcp1), 32'd0);
    chk("rst_addr", 32'(bus.imem_addr), 32'h0000_0C00);
    chk("first_req", 32'(bus.imem_req), 32'd1);

    // sequential fetch
    repeat (3) step(1'b0, 1'b0, '0, 1'b0);
    chk("seq_pcp1", 32'(if_id_pcp1), 32'h0000_0C03);

    // stall at 0xC03 with an ignored redirect, then resume
    step(1'b1, 1'b0, '0, 1'b0);
    step(1'b1, 1'b1, 30'h123, 1'b0);
    step(1'b1, 1'b0, '0, 1'b0);
    step(1'b0, 1'b0, '0, 1'b0);
    chk("resume_pcp1", 32'(if_id_pcp1), 32'h0000_0C04);

    // redirect at 0xC05
    step(1'b0, 1'b0, '0, 1'b0);
    step(1'b0, 1'b1, 30'h418, 1'b0);
    chk("redir_addr", 32'(bus.imem_addr), 32'h0000_0418);
    step(1'b0, 1'b0, '0, 1'b0);
    chk("redir_pcp1", 32'(if_id_pcp1), 32'h0000_0419);

    // flush under stall, then flush+redirect
    step(1'b1, 1'b0, '0, 1'b1);
    step(1'b0, 1'b0, '0, 1'b0);
    step(1'b0, 1'b1, 30'h200, 1'b1);
    step(1'b0, 1'b0, '0, 1'b0);

    // PC wrap
    step(1'b0, 1'b1, 30'h3FFF_FFFF, 1'b0);
    step(1'b0, 1'b0, '0, 1'b0);
    chk("wrap_pcp1", 32'(if_id_pcp1), 32'd0);
    chk("wrap_addr", 32'(bus.imem_addr), 32'd0);

    repeat (40) step($urandom_range(0, 3) == 0, $urandom_range(0, 5) == 0,
                     30'($urandom), $urandom_range(0, 7) == 0);

`ifdef IMEM_WAIT_EN
    // wait states at 0xC02 with a redirect to 0x500 in the first wait cycle
    step(1'b0, 1'b1, 30'hC02, 1'b0);
    for (int w = 0; w < 3; w++) begin
      @(negedge clk);
      bus.imem_ready = 1'b0; stall = 1'b0; flush = 1'b0;
      redirect = (w == 0); npc = 30'h500;
      #1;
      chk("wait_req", 32'(bus.imem_req), 32'd1);
      chk("wait_addr", 32'(bus.imem_addr), 32'h0000_0C02);
      @(posedge clk);
      #1;
      chk("wait_valid", 32'(if_id_valid), 32'd0);
    end
    @(negedge clk);
    bus.imem_ready = 1'b1; redirect = 1'b0;
    #1;
    chk("kill_addr", 32'(bus.imem_addr), 32'h0000_0C02);
    @(posedge clk);
    #1;
    chk("kill_valid", 32'(if_id_valid), 32'd0);
    chk("kill_next", 32'(bus.imem_addr), 32'h0000_0500);
    mv = 1'b0; mi = NOP; mp = '0; mpc = 30'h500;
    step(1'b0, 1'b0, '0, 1'b0);
    chk("kill_pcp1", 32'(if_id_pcp1), 32'h0000_0501);

    // response under stall goes to skid, released after stall drops
    @(negedge clk);
    bus.imem_ready = 1'b0;
    @(negedge clk);
    bus.imem_ready = 1'b1; stall = 1'b1;
    #1;
    chk("hold_req_out", 32'(bus.imem_req), 32'd1);
    @(posedge clk);
    #1;
    chk("hold_req", 32'(bus.imem_req), 32'd0);
    chk("hold_valid", 32'(if_id_valid), 32'd0);
    chk("hold_addr", 32'(bus.imem_addr), 32'h0000_0502);
    @(negedge clk);
    stall = 1'b0;
    #1;
    chk("hold_req2", 32'(bus.imem_req), 32'd0);
    @(posedge clk);
    #1;
    chk("skid_valid", 32'(if_id_valid), 32'd1);
    chk("skid_instr", if_id_instr, mem_word(30'h501));
    chk("skid_pcp1", 32'(if_id_pcp1), 32'h0000_0502);
    mv = 1'b1; mi = mem_word(30'h501); mp = 30'h502; mpc = 30'h502;
    step(1'b0, 1'b0, '0, 1'b0);
    chk("skid_next", 32'(if_id_pcp1), 32'h0000_0503);
`endif

    $display("TB_RESULT checks=%0d failures=%0d", n_chk, n_fail);
    $finish;
  end

endmodule
